// File: rtl/pll_reset_seq_if.sv
// Signal bundle between the PLL lock/reset sequencer and its user.
// The sequencer side is the master; the downstream design is the slave.
interface pll_reset_seq_if #(
  parameter int NUM_CE = 2
);
  logic              pll_lock;
  logic              restart;
  logic              rst_out_n;
  logic              ready;
  logic              lock_lost;
  logic [7:0]        lost_count;
  logic [NUM_CE-1:0] ce;

  modport master (
    input  pll_lock,
    input  restart,
    output rst_out_n,
    output ready,
    output lock_lost,
    output lost_count,
    output ce
  );

  modport slave (
    output pll_lock,
    output restart,
    input  rst_out_n,
    input  ready,
    input  lock_lost,
    input  lost_count,
    input  ce
  );
endinterface

// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and downstream reset generator with
// lock-loss counting and divided clock-enable strobes.
module pll_reset_seq #(
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter int NUM_CE      = 2,
  parameter logic [NUM_CE*16-1:0] CE_DIVS = {16'd4, 16'd2}
) (
  input logic             clock,
  input logic             reset_n,
  pll_reset_seq_if.master bus
);

  localparam int MAXV =
    (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int CW = $clog2(MAXV) + 1;
  localparam logic [CW-1:0] F_END = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] H_END = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    HOLD,
    RUN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          lost_n;
  logic          sync1;
  logic          lock_s;
  logic          run_q;
  logic          lost_q;
  logic [7:0]    lost_cnt;
  logic [NUM_CE-1:0] ce_w;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= bus.pll_lock;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Lock loss has priority over restart in every state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lost_n  = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        cnt_n = '0;
        if (lock_s) state_n = FILTER;
      end
      FILTER: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (bus.restart) begin
          cnt_n = '0;
        end else if (cnt == F_END) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (bus.restart) begin
          cnt_n = '0;
        end else if (cnt == H_END) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          lost_n  = 1'b1;
        end else if (bus.restart) begin
          state_n = HOLD;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      lost_q   <= 1'b0;
      lost_cnt <= '0;
    end else begin
      run_q  <= (state == RUN);
      lost_q <= lost_n;
      if (lost_n && lost_cnt != 8'hFF)
        lost_cnt <= lost_cnt + 8'd1;
    end
  end

  for (genvar k = 0; k < NUM_CE; k++) begin : g_ce
    localparam logic [15:0] DRAW = CE_DIVS[16*k +: 16];
    localparam logic [15:0] DIV =
      (DRAW == 16'd0) ? 16'd1 : DRAW;
    logic [15:0] ck;

    // Held at zero outside RUN so each RUN entry starts a fresh phase.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        ck <= '0;
      end else if (state == RUN && state_n == RUN) begin
        ck <= (ck == DIV - 16'd1) ? 16'd0 : ck + 16'd1;
      end else begin
        ck <= '0;
      end
    end

    assign ce_w[k] = (state == RUN) && (ck == DIV - 16'd1);
  end

  assign bus.rst_out_n  = run_q;
  assign bus.ready      = run_q;
  assign bus.lock_lost  = lost_q;
  assign bus.lost_count = lost_cnt;
  assign bus.ce         = ce_w;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: stimulus queues expected
// rst_out_n edges and lock_lost pulses, a monitor matches them.
module tb_pll_reset_seq;

  localparam int LF  = 4;
  localparam int HC  = 8;
  localparam int NCE = 2;
  localparam logic [31:0] DIVS = {16'd3, 16'd1};

  typedef enum int {
    EV_RISE,
    EV_FALL,
    EV_LOST
  } ev_t;

  typedef struct {
    ev_t kind;
    int  cyc;
    int  lost;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic prev_rst = 1'b0;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_lost = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  pll_reset_seq_if #(.NUM_CE(NCE)) bus ();

  pll_reset_seq #(
    .LOCK_FILTER(LF),
    .HOLD_CYCLES(HC),
    .NUM_CE     (NCE),
    .CE_DIVS    (DIVS)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endfunction

  function automatic void push(ev_t k, int c, int l);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.lost = l;
    q.push_back(e);
  endfunction

  function automatic void seen(ev_t k);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d",
               k, cyc);
    end else begin
      e = q.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      check("event_cycle", cyc, e.cyc);
      check("event_lost_count", int'(bus.lost_count), e.lost);
    end
  endfunction

  // Monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_event: kind %0d due cycle %0d, now %0d",
               q[0].kind, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    check("ready_vs_rst", int'(bus.ready), int'(bus.rst_out_n));
    if (bus.lock_lost) seen(EV_LOST);
    if (prev_rst && !bus.rst_out_n) seen(EV_FALL);
    if (!prev_rst && bus.rst_out_n) seen(EV_RISE);
    prev_rst <= bus.rst_out_n;
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic check_ce_run(input int start);
    logic [1:0] e;
    for (int i = 0; i < 9; i++) begin
      wait_cyc(start + i);
      e = {(i % 3) == 2, 1'b1};
      check("ce_run", int'(bus.ce), int'(e));
    end
  endtask

  task automatic lose_lock();
    int n;
    n = cyc;
    bus.pll_lock = 1'b0;
    exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
    push(EV_LOST, n + 3, exp_lost);
    push(EV_FALL, n + 4, exp_lost);
    wait_cyc(n + 3);
  endtask

  initial begin
    int n;
    int m;
    bus.pll_lock = 1'b1;
    bus.restart  = 1'b0;
    reset_n      = 1'b0;
    repeat (5) @(negedge clock);
    check("reset_rst_out_n", int'(bus.rst_out_n), 0);
    check("reset_ready", int'(bus.ready), 0);
    check("reset_lock_lost", int'(bus.lock_lost), 0);
    check("reset_lost_count", int'(bus.lost_count), 0);
    check("reset_ce", int'(bus.ce), 0);

    // Power-up with lock already high
    n = cyc;
    reset_n = 1'b1;
    push(EV_RISE, n + 16, 0);
    wait_cyc(n + 14);
    check("ce_hold", int'(bus.ce), 0);
    check_ce_run(n + 15);

    // Single lock loss, then chatter before relock
    lose_lock();
    wait_cyc(cyc + 3);
    n = cyc;
    bus.pll_lock = 1'b1;
    wait_cyc(n + 3);
    bus.pll_lock = 1'b0;
    wait_cyc(n + 4);
    bus.pll_lock = 1'b1;
    push(EV_RISE, n + 20, exp_lost);
    wait_cyc(n + 22);

    // Restart in RUN
    n = cyc;
    bus.restart = 1'b1;
    push(EV_FALL, n + 2, exp_lost);
    push(EV_RISE, n + 10, exp_lost);
    wait_cyc(n + 1);
    bus.restart = 1'b0;
    for (int c = n + 1; c <= n + 8; c++) begin
      wait_cyc(c);
      check("ce_restart_hold", int'(bus.ce), 0);
    end
    check_ce_run(n + 9);
    wait_cyc(n + 20);

    // Restart in the same cycle lock_s falls
    n = cyc;
    bus.pll_lock = 1'b0;
    exp_lost++;
    push(EV_LOST, n + 3, exp_lost);
    push(EV_FALL, n + 4, exp_lost);
    wait_cyc(n + 2);
    bus.restart = 1'b1;
    wait_cyc(n + 3);
    bus.restart = 1'b0;
    wait_cyc(n + 6);
    m = cyc;
    bus.pll_lock = 1'b1;
    push(EV_RISE, m + 16, exp_lost);
    wait_cyc(m + 18);

    // Repeated loss/relock until the counter saturates
    for (int i = 0; i < 300; i++) begin
      lose_lock();
      m = cyc;
      bus.pll_lock = 1'b1;
      push(EV_RISE, m + 16, exp_lost);
      wait_cyc(m + 18);
    end
    check("lost_saturated", int'(bus.lost_count), 255);

    // Async reset pulse while in HOLD
    lose_lock();
    m = cyc;
    bus.pll_lock = 1'b1;
    wait_cyc(m + 10);
    #1 reset_n = 1'b0;
    #1;
    check("areset_rst_out_n", int'(bus.rst_out_n), 0);
    check("areset_ready", int'(bus.ready), 0);
    check("areset_lock_lost", int'(bus.lock_lost), 0);
    check("areset_lost_count", int'(bus.lost_count), 0);
    check("areset_ce", int'(bus.ce), 0);
    #1 reset_n = 1'b1;
    exp_lost = 0;
    push(EV_RISE, m + 26, 0);
    wait_cyc(m + 30);

    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
